// File: rtl/sum_acc_pkg.sv
// Shared types and constants for the burst sum accumulator.
package sum_acc_pkg;

  // Default operand/result width in bits.
  localparam int SUM_ACC_DEFAULT_N = 4;

  // Burst sequencing states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } sum_acc_state_t;

endpackage : sum_acc_pkg

// File: rtl/sum_accumulator.sv
// Burst sum accumulator. It adds COUNT operands through an external adder
// and presents the N-bit wrapped sum with a sticky carry-out flag.
//
// state | meaning
// IDLE  | waiting for the first beat of a burst, accumulator cleared
// ACCUM | mid-burst, collecting the remaining beats
// DONE  | result held on out_data/out_ovf until out_ready
module sum_accumulator
  import sum_acc_pkg::*;
#(
  parameter int N     = SUM_ACC_DEFAULT_N,
  parameter int COUNT = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_data,
  output logic [N-1:0] add_a,
  output logic [N-1:0] add_b,
  output logic         add_cin,
  input  logic [N-1:0] add_sum,
  input  logic         add_cout,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_data,
  output logic         out_ovf
);

  // Sized so the count reaches COUNT without wrapping.
  localparam int CW = $clog2(COUNT + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(COUNT - 1);

  sum_acc_state_t r_state;
  logic [N-1:0]   r_acc;
  logic [CW-1:0]  r_cnt;
  logic           r_ovf;
  logic           w_beat;

  // Handshake and adder operand wiring.
  assign in_ready  = (r_state != DONE);
  assign w_beat    = in_valid && in_ready;
  assign add_a     = r_acc;
  assign add_b     = in_data;
  assign add_cin   = 1'b0;
  assign out_valid = (r_state == DONE);
  assign out_data  = r_acc;
  assign out_ovf   = r_ovf;

  // Burst sequencing. IDLE and ACCUM share the beat path: in IDLE the count
  // is zero, so a single-beat burst (COUNT==1) goes straight to DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        IDLE, ACCUM: begin
          if (w_beat) begin
            r_acc <= add_sum;
            r_ovf <= r_ovf | add_cout;
            r_cnt <= r_cnt + CW'(1);
            if (r_cnt == LAST_CNT) begin
              r_state <= DONE;
            end else begin
              r_state <= ACCUM;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            r_state <= IDLE;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_ovf   <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_acc   <= '0;
          r_cnt   <= '0;
          r_ovf   <= 1'b0;
        end
      endcase
    end
  end

endmodule : sum_accumulator

// File: tb/tb_sum_accumulator.sv
// Directed bench for sum_accumulator: a COUNT=4 instance and a COUNT=1
// instance, each paired with a behavioural N-bit adder.
module tb_sum_accumulator;

  localparam int N = 4;

  logic clk;
  logic rst_n;

  logic         in_valid, in_ready, add_cin, add_cout, out_valid, out_ready, out_ovf;
  logic [N-1:0] in_data, add_a, add_b, add_sum, out_data;

  logic         in_valid1, in_ready1, add_cin1, add_cout1, out_valid1, out_ready1, out_ovf1;
  logic [N-1:0] in_data1, add_a1, add_b1, add_sum1, out_data1;

  int n_pass;
  int n_total;

  sum_accumulator #(.N(N), .COUNT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .add_cout(add_cout),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_ovf(out_ovf)
  );

  sum_accumulator #(.N(N), .COUNT(1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid1), .in_ready(in_ready1), .in_data(in_data1),
    .add_a(add_a1), .add_b(add_b1), .add_cin(add_cin1),
    .add_sum(add_sum1), .add_cout(add_cout1),
    .out_valid(out_valid1), .out_ready(out_ready1),
    .out_data(out_data1), .out_ovf(out_ovf1)
  );

  // External adders.
  assign {add_cout, add_sum}   = {1'b0, add_a} + {1'b0, add_b} + {{N{1'b0}}, add_cin};
  assign {add_cout1, add_sum1} = {1'b0, add_a1} + {1'b0, add_b1} + {{N{1'b0}}, add_cin1};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [N-1:0] v);
    in_valid = 1'b1;
    in_data  = v;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic bubble();
    in_valid = 1'b0;
    in_data  = 4'hF;
    tick();
  endtask

  initial begin
    n_pass = 0; n_total = 0;
    rst_n = 1'b0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    in_valid1 = 1'b0; in_data1 = '0; out_ready1 = 1'b0;
    #2;
    chk("rst_out_valid", 8'(out_valid), 8'd0);
    chk("rst_in_ready", 8'(in_ready), 8'd1);
    chk("rst_acc", 8'(add_a), 8'd0);
    chk("add_cin_zero", 8'(add_cin), 8'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // Burst 1,2,3,4 -> 10, no carry.
    out_ready = 1'b1;
    beat(4'd1); beat(4'd2); beat(4'd3);
    chk("b1_not_done", 8'(out_valid), 8'd0);
    beat(4'd4);
    chk("b1_valid", 8'(out_valid), 8'd1);
    chk("b1_data", 8'(out_data), 8'd10);
    chk("b1_ovf", 8'(out_ovf), 8'd0);
    chk("b1_in_ready_done", 8'(in_ready), 8'd0);
    tick();
    chk("b1_back_idle", 8'(out_valid), 8'd0);
    chk("b1_acc_cleared", 8'(add_a), 8'd0);

    // Burst 15,1,0,0 -> 0 with carry; then 1,1,1,1 -> 4, flag cleared.
    beat(4'd15); beat(4'd1);
    chk("b2_wrap_acc", 8'(add_a), 8'd0);
    beat(4'd0); beat(4'd0);
    chk("b2_valid", 8'(out_valid), 8'd1);
    chk("b2_data", 8'(out_data), 8'd0);
    chk("b2_ovf", 8'(out_ovf), 8'd1);
    tick();
    beat(4'd1); beat(4'd1); beat(4'd1); beat(4'd1);
    chk("b3_data", 8'(out_data), 8'd4);
    chk("b3_ovf_cleared", 8'(out_ovf), 8'd0);
    tick();

    // Bubbles: 2,_,3,_,_,4,5 -> 14.
    beat(4'd2);
    bubble();
    chk("bub_acc_hold1", 8'(add_a), 8'd2);
    chk("bub_in_ready", 8'(in_ready), 8'd1);
    beat(4'd3);
    bubble(); bubble();
    chk("bub_acc_hold2", 8'(add_a), 8'd5);
    chk("bub_not_done", 8'(out_valid), 8'd0);
    beat(4'd4); beat(4'd5);
    chk("bub_valid", 8'(out_valid), 8'd1);
    chk("bub_data", 8'(out_data), 8'd14);
    tick();

    // Backpressure: result held for 5 cycles with in_valid=1.
    out_ready = 1'b0;
    beat(4'd1); beat(4'd2); beat(4'd3); beat(4'd4);
    in_valid = 1'b1; in_data = 4'd7;
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", 8'(out_valid), 8'd1);
      chk("bp_in_ready", 8'(in_ready), 8'd0);
      chk("bp_data", 8'(out_data), 8'd10);
      tick();
    end
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("bp_released", 8'(out_valid), 8'd0);
    chk("bp_idle_ready", 8'(in_ready), 8'd1);
    chk("bp_acc_cleared", 8'(add_a), 8'd0);

    // Reset mid-burst after two beats.
    beat(4'd3); beat(4'd5);
    chk("rm_partial", 8'(add_a), 8'd8);
    #2 rst_n = 1'b0;
    #1;
    chk("rm_acc_async", 8'(add_a), 8'd0);
    chk("rm_no_valid", 8'(out_valid), 8'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("rm_still_idle", 8'(out_valid), 8'd0);
    beat(4'd1); beat(4'd1); beat(4'd1);
    chk("rm_cnt_restarted", 8'(out_valid), 8'd0);
    beat(4'd1);
    chk("rm_valid", 8'(out_valid), 8'd1);
    chk("rm_data", 8'(out_data), 8'd4);
    tick();

    // Reset while a result is pending.
    out_ready = 1'b0;
    beat(4'd9); beat(4'd9); beat(4'd1); beat(4'd1);
    chk("rd_pending", 8'(out_valid), 8'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rd_dropped", 8'(out_valid), 8'd0);
    chk("rd_ovf_cleared", 8'(out_ovf), 8'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // Single-beat bursts.
    in_valid1 = 1'b1; in_data1 = 4'd9;
    tick();
    in_valid1 = 1'b0;
    chk("c1_valid", 8'(out_valid1), 8'd1);
    chk("c1_data", 8'(out_data1), 8'd9);
    chk("c1_ovf", 8'(out_ovf1), 8'd0);
    out_ready1 = 1'b1;
    tick();
    chk("c1_idle", 8'(out_valid1), 8'd0);
    in_valid1 = 1'b1; in_data1 = 4'd6;
    tick();
    in_valid1 = 1'b0;
    chk("c1_second", 8'(out_data1), 8'd6);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_sum_accumulator
